// File: rtl/lsb_commit_pkg.sv
// Shared definitions for the load/store buffer: funct3 codes for the memory
// ops, FSM state encoding, default widths and the entry payload layout.
package lsb_commit_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int LSB_WIDTH_DEF = 3;

    // funct3 codes; stores reuse the width codes of the signed loads
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } lsb_state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        store;
        logic [31:0] addr;
        logic [31:0] data;
    } lsb_entry_t;

    // Number of bytes moved by an op, taken from the width bits of funct3
    function automatic logic [2:0] op_bytes(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsb_commit_if.sv
// Bundle of the issue, ROB commit/result and byte-RAM signals around the
// load/store buffer. The master side is the surrounding core, the slave side
// is the buffer itself.
interface lsb_commit_if import lsb_commit_pkg::*; #(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) ();

    logic                 clear;
    logic                 from_issue;
    logic [ROB_WIDTH-1:0] from_issue_tag;
    logic [2:0]           from_issue_op;
    logic                 from_issue_store;
    logic [31:0]          from_issue_addr;
    logic [31:0]          from_issue_data;
    logic                 from_rob;
    logic [ROB_WIDTH-1:0] from_rob_tag;
    logic [7:0]           mem_din;
    logic                 io_buffer_full;
    logic [31:0]          mem_a;
    logic [7:0]           mem_dout;
    logic                 mem_wr;
    logic                 full;
    logic                 to_rob;
    logic [ROB_WIDTH-1:0] to_rob_tag;
    logic [31:0]          to_rob_data;

    modport master (
        output clear, from_issue, from_issue_tag, from_issue_op, from_issue_store,
               from_issue_addr, from_issue_data, from_rob, from_rob_tag,
               mem_din, io_buffer_full,
        input  mem_a, mem_dout, mem_wr, full, to_rob, to_rob_tag, to_rob_data
    );

    modport slave (
        input  clear, from_issue, from_issue_tag, from_issue_op, from_issue_store,
               from_issue_addr, from_issue_data, from_rob, from_rob_tag,
               mem_din, io_buffer_full,
        output mem_a, mem_dout, mem_wr, full, to_rob, to_rob_tag, to_rob_data
    );

endinterface

// File: rtl/lsb_load_ext.sv
// Sign/zero extension of the assembled load bytes according to funct3.
module lsb_load_ext import lsb_commit_pkg::*; (
    input  logic [31:0] raw,
    input  logic [2:0]  op,
    output logic [31:0] value
);

    // Select the extension for byte/half loads; words pass through
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        value = raw;
        case (op)
            F3_LB:   value = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   value = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  value = {24'b0, raw[7:0]};
            F3_LHU:  value = {16'b0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/lsb_commit.sv
// Load/store buffer on the responder side of the ROB commit interface.
// Ops are queued in program order at issue, executed bytewise against the RAM
// only once the ROB commits their tag, and load results are returned with the
// same tag. A clear drops every entry that has not been committed yet.
// Optional feature: define LSB_IO_STALL_EN to hold stores to IO space
// (addr[17:16] == 2'b11) while the UART buffer reports full.
module lsb_commit import lsb_commit_pkg::*; #(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int LSB_WIDTH = LSB_WIDTH_DEF,
    parameter int LSB_SIZE  = 2 ** LSB_WIDTH
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    lsb_commit_if.slave  bus
);

    localparam logic [LSB_WIDTH:0] SIZE_CNT = (LSB_WIDTH + 1)'(LSB_SIZE);

    lsb_entry_t           entry [LSB_SIZE];
    logic [ROB_WIDTH-1:0] tag_q [LSB_SIZE];
    logic [LSB_SIZE-1:0]  committed;
    logic [LSB_WIDTH-1:0] head, tail, head_n, tail_n;
    logic [LSB_WIDTH:0]   count, ccount, count_n, ccount_n;
    logic [LSB_SIZE-1:0]  commit_hit;
    logic                 do_alloc;

    lsb_state_t           state, state_next;
    logic [1:0]           k;
    logic [31:0]          load_buf;
    logic                 k_clr, k_inc, capture, retire;

    lsb_entry_t           head_e;
    logic [2:0]           n_bytes;
    logic                 last_byte;
    logic                 io_stall;
    logic [31:0]          ext_value;

    assign head_e    = entry[head];
    assign n_bytes   = op_bytes(head_e.op);
    assign last_byte = ({1'b0, k} == n_bytes - 3'd1);

`ifdef LSB_IO_STALL_EN
    assign io_stall = head_e.store && (head_e.addr[17:16] == 2'b11) && bus.io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = bus.io_buffer_full;
    assign io_stall = 1'b0;
`endif

    lsb_load_ext u_load_ext (
        .raw   (load_buf),
        .op    (head_e.op),
        .value (ext_value)
    );

    // Queue bookkeeping: allocation, commit matching, retire and flush
    always_comb begin
        do_alloc   = bus.from_issue && !bus.clear && (count != SIZE_CNT);
        commit_hit = '0;
        for (int i = 0; i < LSB_SIZE; i++) begin
            if (bus.from_rob && !bus.clear && !committed[i] &&
                (tag_q[i] == bus.from_rob_tag) &&
                ({1'b0, LSB_WIDTH'(i) - head} < count)) begin
                commit_hit[i] = 1'b1;
            end
        end
        head_n = head + LSB_WIDTH'(retire);
        if (bus.clear) begin
            // committed entries form a prefix from head, so they survive intact
            tail_n   = head + ccount[LSB_WIDTH-1:0];
            count_n  = ccount - (LSB_WIDTH + 1)'(retire);
            ccount_n = ccount - (LSB_WIDTH + 1)'(retire);
        end else begin
            tail_n   = tail + LSB_WIDTH'(do_alloc);
            count_n  = count + (LSB_WIDTH + 1)'(do_alloc) - (LSB_WIDTH + 1)'(retire);
            ccount_n = ccount + (LSB_WIDTH + 1)'(|commit_hit) - (LSB_WIDTH + 1)'(retire);
        end
    end

    // Queue pointers, counters, commit flags and the registered full flag
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ccount    <= '0;
            committed <= '0;
            bus.full  <= 1'b0;
        end else if (rdy_in) begin
            head     <= head_n;
            tail     <= tail_n;
            count    <= count_n;
            ccount   <= ccount_n;
            bus.full <= (count_n == SIZE_CNT);
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (commit_hit[i]) committed[i] <= 1'b1;
            end
            if (do_alloc) committed[tail] <= 1'b0;
        end
    end

    // Entry payload write at the tail on allocation
    always_ff @(posedge clk_in) begin
        // NOTE: payload storage has no reset; head/count decide validity, so stale contents are never used.
        if (rst_in && rdy_in && do_alloc) begin
            entry[tail] <= '{op:    bus.from_issue_op,
                             store: bus.from_issue_store,
                             addr:  bus.from_issue_addr,
                             data:  bus.from_issue_data};
            tag_q[tail] <= bus.from_issue_tag;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else if (rdy_in) state <= state_next;
    end

    // Byte counter and load assembly buffer
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            k        <= '0;
            load_buf <= '0;
        end else if (rdy_in) begin
            if (k_clr) begin
                k        <= '0;
                load_buf <= '0;
            end else if (k_inc) begin
                k <= k + 2'd1;
            end
            if (capture) load_buf[{k, 3'b000} +: 8] <= bus.mem_din;
        end
    end

    // FSM next state and RAM/result outputs
    always_comb begin
        state_next      = state;
        k_clr           = 1'b0;
        k_inc           = 1'b0;
        capture         = 1'b0;
        retire          = 1'b0;
        bus.mem_a       = '0;
        bus.mem_dout    = '0;
        bus.mem_wr      = 1'b0;
        bus.to_rob      = 1'b0;
        bus.to_rob_tag  = '0;
        bus.to_rob_data = '0;
        case (state)
            IDLE: begin
                if ((count != '0) && committed[head]) begin
                    state_next = ACCESS;
                    k_clr      = 1'b1;
                end
            end
            ACCESS: begin
                bus.mem_a = head_e.addr + {30'b0, k};
                if (head_e.store) begin
                    if (!io_stall) begin
                        bus.mem_dout = head_e.data[{k, 3'b000} +: 8];
                        bus.mem_wr   = rdy_in;
                        k_inc        = 1'b1;
                        if (last_byte) state_next = DONE;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                capture    = 1'b1;
                k_inc      = 1'b1;
                state_next = last_byte ? DONE : ACCESS;
            end
            DONE: begin
                retire     = 1'b1;
                state_next = IDLE;
                if (!head_e.store) begin
                    bus.to_rob      = rdy_in;
                    bus.to_rob_tag  = tag_q[head];
                    bus.to_rob_data = ext_value;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsb_commit.sv
// Scoreboard bench for lsb_commit: expected RAM writes and load results are
// queued when an op is issued; a negedge monitor pops and compares them
// whenever the DUT writes the RAM or returns a result.
module tb_lsb_commit;
    import lsb_commit_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    always #5 clk_in = ~clk_in;

    lsb_commit_if #(.ROB_WIDTH(4)) bus ();

    lsb_commit #(.ROB_WIDTH(4), .LSB_WIDTH(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [3:0] tag; logic [31:0] data; } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];
    int   wr_cycles[$];
    int   res_cycles[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic [7:0] ram [0:4095];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous byte RAM: read data appears the cycle after the address
    always @(posedge clk_in) begin
        if (bus.mem_wr === 1'b1) ram[bus.mem_a[11:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    // Monitor: compare every DUT write/result against the scoreboard
    always @(negedge clk_in) begin : monitor
        wr_t  ew;
        res_t er;
        if (rst_in) begin
            if (bus.mem_wr === 1'b1) begin
                wr_cycles.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%08h byte 0x%02h, none expected", bus.mem_a, bus.mem_dout);
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", bus.mem_a, ew.addr);
                    check("wr_data", {24'b0, bus.mem_dout}, {24'b0, ew.data});
                end
            end
            if (bus.to_rob === 1'b1) begin
                res_cycles.push_back(cyc);
                if (exp_res.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got tag %0d data 0x%08h, none expected", bus.to_rob_tag, bus.to_rob_data);
                end else begin
                    er = exp_res.pop_front();
                    check("res_tag", {28'b0, bus.to_rob_tag}, {28'b0, er.tag});
                    check("res_data", bus.to_rob_data, er.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [3:0] tag, input logic [2:0] op, input logic st,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.from_issue       = 1'b1;
        bus.from_issue_tag   = tag;
        bus.from_issue_op    = op;
        bus.from_issue_store = st;
        bus.from_issue_addr  = addr;
        bus.from_issue_data  = data;
        tick(1);
        bus.from_issue = 1'b0;
    endtask

    task automatic commit(input logic [3:0] tag, output int c0);
        bus.from_rob     = 1'b1;
        bus.from_rob_tag = tag;
        tick(1);
        c0 = cyc;
        bus.from_rob = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [7:0] data);
        exp_wr.push_back('{addr: addr, data: data});
    endtask

    task automatic push_res(input logic [3:0] tag, input logic [31:0] data);
        exp_res.push_back('{tag: tag, data: data});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c0;
        int guard;
        bus.clear            = 1'b0;
        bus.from_issue       = 1'b0;
        bus.from_issue_tag   = '0;
        bus.from_issue_op    = '0;
        bus.from_issue_store = 1'b0;
        bus.from_issue_addr  = '0;
        bus.from_issue_data  = '0;
        bus.from_rob         = 1'b0;
        bus.from_rob_tag     = '0;
        bus.io_buffer_full   = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h200] = 8'h80;
        ram[12'h1FF] = 8'hF0;

        // Power-on reset
        tick(2);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("rst_full", {31'b0, bus.full}, 32'd0);
        check("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_to_rob", {31'b0, bus.to_rob}, 32'd0);
        check("rst_to_rob_data", bus.to_rob_data, 32'd0);

        // Reset with a full queue
        for (int i = 0; i < 8; i++) issue(4'(i), F3_LW, 1'b0, 32'h40 * i, 32'd0);
        @(negedge clk_in);
        check("full_before_reset", {31'b0, bus.full}, 32'd1);
        rst_in = 1'b0;
        tick(2);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("full_after_reset", {31'b0, bus.full}, 32'd0);
        check("mem_wr_after_reset", {31'b0, bus.mem_wr}, 32'd0);
        check("to_rob_after_reset", {31'b0, bus.to_rob}, 32'd0);

        // SW 0x11223344 to 0x100: bytes 44,33,22,11 on consecutive cycles
        issue(4'd3, F3_SW, 1'b1, 32'h100, 32'h11223344);
        push_wr(32'h100, 8'h44);
        push_wr(32'h101, 8'h33);
        push_wr(32'h102, 8'h22);
        push_wr(32'h103, 8'h11);
        wr_cycles.delete();
        commit(4'd3, c0);
        tick(8);
        check("sw_write_count", wr_cycles.size(), 32'd4);
        if (wr_cycles.size() == 4) begin
            check("sw_first_write_cycle", wr_cycles[0], c0 + 1);
            check("sw_last_write_cycle", wr_cycles[3], c0 + 4);
        end

        // LB of 0x80 sign-extends; result shows in the DONE cycle
        issue(4'd5, F3_LB, 1'b0, 32'h200, 32'd0);
        push_res(4'd5, 32'hFFFFFF80);
        res_cycles.delete();
        commit(4'd5, c0);
        tick(6);
        check("lb_result_count", res_cycles.size(), 32'd1);
        if (res_cycles.size() == 1) check("lb_result_cycle", res_cycles[0], c0 + 3);

        // Mixed loads including misaligned halves
        issue(4'd6, F3_LBU, 1'b0, 32'h200, 32'd0);
        push_res(4'd6, 32'h00000080);
        issue(4'd7, F3_LH, 1'b0, 32'h101, 32'd0);
        push_res(4'd7, 32'h00002233);
        issue(4'd8, F3_LHU, 1'b0, 32'h1FF, 32'd0);
        push_res(4'd8, 32'h000080F0);
        issue(4'd9, F3_LH, 1'b0, 32'h1FF, 32'd0);
        push_res(4'd9, 32'hFFFF80F0);
        issue(4'd10, F3_LW, 1'b0, 32'h100, 32'd0);
        push_res(4'd10, 32'h11223344);
        for (int t = 6; t <= 10; t++) commit(4'(t), c0);
        tick(60);

        // Fill to full, ignored 9th allocate, full drop after retire, tail wrap
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                @(negedge clk_in);
                check("full_at_7", {31'b0, bus.full}, 32'd0);
            end
            issue(4'(i), F3_SB, 1'b1, 32'h300 + i, 32'hA0 + i);
            push_wr(32'h300 + i, 8'(8'hA0 + i));
        end
        @(negedge clk_in);
        check("full_at_8", {31'b0, bus.full}, 32'd1);
        issue(4'd8, F3_SB, 1'b1, 32'h3F0, 32'hEE);
        commit(4'd0, c0);
        repeat (3) @(negedge clk_in);
        check("full_in_done_cycle", {31'b0, bus.full}, 32'd1);
        @(negedge clk_in);
        check("full_after_retire", {31'b0, bus.full}, 32'd0);
        issue(4'd9, F3_SB, 1'b1, 32'h3F8, 32'hC9);
        push_wr(32'h3F8, 8'hC9);
        for (int t = 1; t <= 7; t++) commit(4'(t), c0);
        commit(4'd9, c0);
        tick(30);
        check("full_after_drain", {31'b0, bus.full}, 32'd0);

        // Clear with tag 1 committed and in flight; tags 2/3 dropped
        issue(4'd1, F3_LW, 1'b0, 32'h100, 32'd0);
        push_res(4'd1, 32'h11223344);
        issue(4'd2, F3_SW, 1'b1, 32'h500, 32'hDEADBEEF);
        issue(4'd3, F3_SB, 1'b1, 32'h501, 32'h77);
        commit(4'd1, c0);
        bus.clear            = 1'b1;
        bus.from_issue       = 1'b1;
        bus.from_issue_tag   = 4'd4;
        bus.from_issue_op    = F3_SB;
        bus.from_issue_store = 1'b1;
        bus.from_issue_addr  = 32'h600;
        bus.from_issue_data  = 32'h55;
        bus.from_rob         = 1'b1;
        bus.from_rob_tag     = 4'd2;
        tick(1);
        bus.clear      = 1'b0;
        bus.from_issue = 1'b0;
        bus.from_rob   = 1'b0;
        commit(4'd2, c0);
        commit(4'd3, c0);
        commit(4'd4, c0);
        tick(20);
        // Queue must be empty now: full rises exactly on the 8th allocate
        for (int i = 0; i < 7; i++) issue(4'(i), F3_LB, 1'b0, 32'd0, 32'd0);
        @(negedge clk_in);
        check("post_clear_full_at_7", {31'b0, bus.full}, 32'd0);
        issue(4'd7, F3_LB, 1'b0, 32'd0, 32'd0);
        @(negedge clk_in);
        check("post_clear_full_at_8", {31'b0, bus.full}, 32'd1);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        @(negedge clk_in);
        check("full_after_clear", {31'b0, bus.full}, 32'd0);
        tick(5);

        // Store to IO space with the UART buffer full
        issue(4'd11, F3_SB, 1'b1, 32'h30000, 32'h5A);
        push_wr(32'h30000, 8'h5A);
        bus.io_buffer_full = 1'b1;
        wr_cycles.delete();
        commit(4'd11, c0);
        tick(5);
`ifdef LSB_IO_STALL_EN
        check("io_stall_no_write", wr_cycles.size(), 32'd0);
        bus.io_buffer_full = 1'b0;
        tick(3);
        check("io_write_count", wr_cycles.size(), 32'd1);
        if (wr_cycles.size() == 1) check("io_write_cycle", wr_cycles[0], c0 + 5);
`else
        check("io_write_count", wr_cycles.size(), 32'd1);
        if (wr_cycles.size() == 1) check("io_write_cycle", wr_cycles[0], c0 + 1);
        bus.io_buffer_full = 1'b0;
`endif

        // Drain and confirm every expectation was consumed
        guard = 0;
        while ((exp_wr.size() != 0 || exp_res.size() != 0) && guard < 200) begin
            tick(1);
            guard++;
        end
        check("writes_outstanding", exp_wr.size(), 32'd0);
        check("results_outstanding", exp_res.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
